// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises pulse-unit, io-unit and panel accesses onto the
// single memory port with fixed priority pnl > pu > io and routes each reply
// back to the requester that owns the access.
// Optional reply watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned DATA_W         = 37,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_read_from_pu,
    input  logic [ADDR_W-1:0] addr_from_pu,
    input  logic              mem_write_from_io,
    input  logic [ADDR_W-1:0] addr_from_io,
    input  logic [DATA_W-1:0] wdata_from_io,
    input  logic              mem_req_from_pnl,
    input  logic              we_from_pnl,
    input  logic [ADDR_W-1:0] addr_from_pnl,
    input  logic [DATA_W-1:0] wdata_from_pnl,
    input  logic              clear_arb_from_pnl,
    output logic              mem_req_to_mem,
    output logic              we_to_mem,
    output logic [ADDR_W-1:0] addr_to_mem,
    output logic [DATA_W-1:0] wdata_to_mem,
    input  logic              reply_from_mem,
    output logic              reply_to_pu,
    output logic              reply_to_io,
    output logic              reply_to_pnl,
    output logic              overrun_to_pnl,
    output logic              timeout_to_pnl,
    output logic [1:0]        arb_state_to_pnl
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_e;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_PNL = 2'd1, OWN_PU = 2'd2, OWN_IO = 2'd3} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              pend_pu_q, pend_pu_d, pend_io_q, pend_io_d, pend_pnl_q, pend_pnl_d;
    logic [ADDR_W-1:0] pu_addr_q, pu_addr_d, io_addr_q, io_addr_d, pnl_addr_q, pnl_addr_d;
    logic [DATA_W-1:0] io_wdata_q, io_wdata_d, pnl_wdata_q, pnl_wdata_d;
    logic              pnl_we_q, pnl_we_d;
    logic              mem_req_q, mem_req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              overrun_q, overrun_d;
    logic              finish_c, busy_c, timeout_hit_c;
    logic              drop_pu_c, drop_io_c, drop_pnl_c;
    logic              take_pu_c, take_io_c, take_pnl_c;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // Watchdog expires after TIMEOUT_CYCLES reply-less WAIT cycles
    assign timeout_hit_c  = (state_q == ST_WAIT) && !reply_from_mem &&
                            (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign timeout_to_pnl = timeout_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit_c  = 1'b0;
    assign timeout_to_pnl = 1'b0;
`endif

    // Access completes on a WAIT-state reply (or watchdog) unless cleared/reset
    assign finish_c = resetn && !clear_arb_from_pnl && (state_q == ST_WAIT) &&
                      (reply_from_mem || timeout_hit_c);
    assign busy_c   = (state_q != ST_IDLE) && !finish_c;

    // A pulse is dropped if its requester already has one pending or owns the access
    assign drop_pu_c  = mem_read_from_pu  && !clear_arb_from_pnl &&
                        (pend_pu_q  || (busy_c && owner_q == OWN_PU));
    assign drop_io_c  = mem_write_from_io && !clear_arb_from_pnl &&
                        (pend_io_q  || (busy_c && owner_q == OWN_IO));
    assign drop_pnl_c = mem_req_from_pnl  && !clear_arb_from_pnl &&
                        (pend_pnl_q || (busy_c && owner_q == OWN_PNL));
    assign take_pu_c  = mem_read_from_pu  && !clear_arb_from_pnl && !drop_pu_c;
    assign take_io_c  = mem_write_from_io && !clear_arb_from_pnl && !drop_io_c;
    assign take_pnl_c = mem_req_from_pnl  && !clear_arb_from_pnl && !drop_pnl_c;

    // Reply is forwarded combinationally to the owner only
    assign reply_to_pu  = finish_c && (owner_q == OWN_PU);
    assign reply_to_io  = finish_c && (owner_q == OWN_IO);
    assign reply_to_pnl = finish_c && (owner_q == OWN_PNL);

    assign mem_req_to_mem   = mem_req_q;
    assign we_to_mem        = we_q;
    assign addr_to_mem      = addr_q;
    assign wdata_to_mem     = wdata_q;
    assign overrun_to_pnl   = overrun_q;
    assign arb_state_to_pnl = state_q;

    // Next-state: request capture, priority select, access sequencing, clear
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        pend_pu_d   = pend_pu_q;
        pend_io_d   = pend_io_q;
        pend_pnl_d  = pend_pnl_q;
        pu_addr_d   = pu_addr_q;
        io_addr_d   = io_addr_q;
        io_wdata_d  = io_wdata_q;
        pnl_addr_d  = pnl_addr_q;
        pnl_wdata_d = pnl_wdata_q;
        pnl_we_d    = pnl_we_q;
        mem_req_d   = 1'b0;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        overrun_d   = overrun_q | drop_pu_c | drop_io_c | drop_pnl_c;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = timeout_q | (finish_c && timeout_hit_c);
`endif

        if (take_pu_c) begin
            pend_pu_d = 1'b1;
            pu_addr_d = addr_from_pu;
        end
        if (take_io_c) begin
            pend_io_d  = 1'b1;
            io_addr_d  = addr_from_io;
            io_wdata_d = wdata_from_io;
        end
        if (take_pnl_c) begin
            pend_pnl_d  = 1'b1;
            pnl_addr_d  = addr_from_pnl;
            pnl_wdata_d = wdata_from_pnl;
            pnl_we_d    = we_from_pnl;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pend_pnl_q) begin
                    owner_d = OWN_PNL; pend_pnl_d = 1'b0; state_d = ST_ISSUE; mem_req_d = 1'b1;
                    we_d = pnl_we_q; addr_d = pnl_addr_q; wdata_d = pnl_wdata_q;
                end else if (pend_pu_q) begin
                    owner_d = OWN_PU; pend_pu_d = 1'b0; state_d = ST_ISSUE; mem_req_d = 1'b1;
                    we_d = 1'b0; addr_d = pu_addr_q; wdata_d = '0;
                end else if (pend_io_q) begin
                    owner_d = OWN_IO; pend_io_d = 1'b0; state_d = ST_ISSUE; mem_req_d = 1'b1;
                    we_d = 1'b1; addr_d = io_addr_q; wdata_d = io_wdata_q;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (finish_c) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        if (clear_arb_from_pnl) begin
            state_d    = ST_IDLE;
            owner_d    = OWN_NONE;
            pend_pu_d  = 1'b0;
            pend_io_d  = 1'b0;
            pend_pnl_d = 1'b0;
            mem_req_d  = 1'b0;
            overrun_d  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            timeout_d  = 1'b0;
`endif
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            pend_pu_q   <= 1'b0;
            pend_io_q   <= 1'b0;
            pend_pnl_q  <= 1'b0;
            pu_addr_q   <= '0;
            io_addr_q   <= '0;
            io_wdata_q  <= '0;
            pnl_addr_q  <= '0;
            pnl_wdata_q <= '0;
            pnl_we_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            overrun_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            pend_pu_q   <= pend_pu_d;
            pend_io_q   <= pend_io_d;
            pend_pnl_q  <= pend_pnl_d;
            pu_addr_q   <= pu_addr_d;
            io_addr_q   <= io_addr_d;
            io_wdata_q  <= io_wdata_d;
            pnl_addr_q  <= pnl_addr_d;
            pnl_wdata_q <= pnl_wdata_d;
            pnl_we_q    <= pnl_we_d;
            mem_req_q   <= mem_req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            overrun_q   <= overrun_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 37;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 255;
`endif

    logic              clk;
    logic              resetn;
    logic              mem_read_from_pu;
    logic [ADDR_W-1:0] addr_from_pu;
    logic              mem_write_from_io;
    logic [ADDR_W-1:0] addr_from_io;
    logic [DATA_W-1:0] wdata_from_io;
    logic              mem_req_from_pnl;
    logic              we_from_pnl;
    logic [ADDR_W-1:0] addr_from_pnl;
    logic [DATA_W-1:0] wdata_from_pnl;
    logic              clear_arb_from_pnl;
    logic              mem_req_to_mem;
    logic              we_to_mem;
    logic [ADDR_W-1:0] addr_to_mem;
    logic [DATA_W-1:0] wdata_to_mem;
    logic              reply_from_mem;
    logic              reply_to_pu;
    logic              reply_to_io;
    logic              reply_to_pnl;
    logic              overrun_to_pnl;
    logic              timeout_to_pnl;
    logic [1:0]        arb_state_to_pnl;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int n_rpu = 0;
    int n_rio = 0;
    int n_rpnl = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .mem_read_from_pu(mem_read_from_pu), .addr_from_pu(addr_from_pu),
        .mem_write_from_io(mem_write_from_io), .addr_from_io(addr_from_io),
        .wdata_from_io(wdata_from_io),
        .mem_req_from_pnl(mem_req_from_pnl), .we_from_pnl(we_from_pnl),
        .addr_from_pnl(addr_from_pnl), .wdata_from_pnl(wdata_from_pnl),
        .clear_arb_from_pnl(clear_arb_from_pnl),
        .mem_req_to_mem(mem_req_to_mem), .we_to_mem(we_to_mem),
        .addr_to_mem(addr_to_mem), .wdata_to_mem(wdata_to_mem),
        .reply_from_mem(reply_from_mem),
        .reply_to_pu(reply_to_pu), .reply_to_io(reply_to_io), .reply_to_pnl(reply_to_pnl),
        .overrun_to_pnl(overrun_to_pnl), .timeout_to_pnl(timeout_to_pnl),
        .arb_state_to_pnl(arb_state_to_pnl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled just before each active edge
    always @(posedge clk) begin
        if (mem_req_to_mem) n_strobe++;
        if (reply_to_pu)    n_rpu++;
        if (reply_to_io)    n_rio++;
        if (reply_to_pnl)   n_rpnl++;
    end

    // Advance to just after the next edge and drop all one-cycle pulses
    task automatic step();
        @(posedge clk);
        #1;
        mem_read_from_pu   = 1'b0;
        mem_write_from_io  = 1'b0;
        mem_req_from_pnl   = 1'b0;
        clear_arb_from_pnl = 1'b0;
        reply_from_mem     = 1'b0;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        mem_read_from_pu = 1'b0; addr_from_pu = '0;
        mem_write_from_io = 1'b0; addr_from_io = '0; wdata_from_io = '0;
        mem_req_from_pnl = 1'b0; we_from_pnl = 1'b0; addr_from_pnl = '0; wdata_from_pnl = '0;
        clear_arb_from_pnl = 1'b0; reply_from_mem = 1'b0;
        step(); step(); step();
        resetn = 1'b1;
        samp();
        checks++; if (arb_state_to_pnl !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", arb_state_to_pnl); end
        checks++; if ({mem_req_to_mem, we_to_mem} !== 2'b00) begin errors++; $display("FAIL reset_req_we: got %b expected 00", {mem_req_to_mem, we_to_mem}); end
        checks++; if (addr_to_mem !== '0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", addr_to_mem); end
        checks++; if (wdata_to_mem !== '0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", wdata_to_mem); end
        checks++; if ({reply_to_pu, reply_to_io, reply_to_pnl} !== 3'b000) begin errors++; $display("FAIL reset_replies: got %b expected 000", {reply_to_pu, reply_to_io, reply_to_pnl}); end
        checks++; if ({overrun_to_pnl, timeout_to_pnl} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {overrun_to_pnl, timeout_to_pnl}); end
    endtask

    task automatic test_single_pu();
        int b_s, b_pu, b_io, b_pnl;
        b_s = n_strobe; b_pu = n_rpu; b_io = n_rio; b_pnl = n_rpnl;
        step(); mem_read_from_pu = 1'b1; addr_from_pu = 10'o1234;     // t
        samp();
        checks++; if (arb_state_to_pnl !== 2'd0) begin errors++; $display("FAIL pu_t_state: got %0d expected 0", arb_state_to_pnl); end
        step(); addr_from_pu = 10'o0000;                             // t+1
        samp();
        checks++; if (mem_req_to_mem !== 1'b0) begin errors++; $display("FAIL pu_t1_req: got %b expected 0", mem_req_to_mem); end
        step(); samp();                                               // t+2
        checks++; if ({mem_req_to_mem, we_to_mem} !== 2'b10) begin errors++; $display("FAIL pu_strobe_req_we: got %b expected 10", {mem_req_to_mem, we_to_mem}); end
        checks++; if (addr_to_mem !== 10'o1234) begin errors++; $display("FAIL pu_strobe_addr: got %0o expected 1234", addr_to_mem); end
        checks++; if (arb_state_to_pnl !== 2'd1) begin errors++; $display("FAIL pu_issue_state: got %0d expected 1", arb_state_to_pnl); end
        step(); samp();                                               // t+3
        checks++; if ({mem_req_to_mem, arb_state_to_pnl} !== 3'b0_10) begin errors++; $display("FAIL pu_wait: got %b expected 010", {mem_req_to_mem, arb_state_to_pnl}); end
        checks++; if (addr_to_mem !== 10'o1234) begin errors++; $display("FAIL pu_wait_addr_hold: got %0o expected 1234", addr_to_mem); end
        step();                                                       // t+4
        step(); reply_from_mem = 1'b1;                                // t+5
        samp();
        checks++; if ({reply_to_pu, reply_to_io, reply_to_pnl} !== 3'b100) begin errors++; $display("FAIL pu_reply_route: got %b expected 100", {reply_to_pu, reply_to_io, reply_to_pnl}); end
        step(); samp();                                               // t+6
        checks++; if ({reply_to_pu, arb_state_to_pnl} !== 3'b0_00) begin errors++; $display("FAIL pu_after_reply: got %b expected 000", {reply_to_pu, arb_state_to_pnl}); end
        step();
        checks++; if ((n_strobe - b_s) != 1 || (n_rpu - b_pu) != 1 || (n_rio - b_io) != 0 || (n_rpnl - b_pnl) != 0) begin
            errors++; $display("FAIL pu_pulse_counts: got strobe=%0d pu=%0d io=%0d pnl=%0d expected 1 1 0 0",
                               n_strobe - b_s, n_rpu - b_pu, n_rio - b_io, n_rpnl - b_pnl); end
    endtask

    task automatic test_simultaneous();
        logic              exp_we    [3];
        logic [ADDR_W-1:0] exp_addr  [3];
        logic [DATA_W-1:0] exp_wdata [3];
        logic [2:0]        exp_rep   [3];
        logic              chk_wdata [3];
        int waited;
        logic found;
        exp_we = '{1'b1, 1'b0, 1'b1};
        exp_addr = '{10'o0777, 10'o0555, 10'o0042};
        exp_wdata = '{37'h1_2345_6789, 37'h0, 37'h0_0ABC_DEF0};
        exp_rep = '{3'b001, 3'b100, 3'b010};          // {pu, io, pnl}
        chk_wdata = '{1'b1, 1'b0, 1'b1};
        step();
        mem_req_from_pnl = 1'b1; we_from_pnl = 1'b1; addr_from_pnl = 10'o0777; wdata_from_pnl = 37'h1_2345_6789;
        mem_write_from_io = 1'b1; addr_from_io = 10'o0042; wdata_from_io = 37'h0_0ABC_DEF0;
        mem_read_from_pu = 1'b1; addr_from_pu = 10'o0555;
        samp();
        for (int k = 0; k < 3; k++) begin
            waited = 0; found = 1'b0;
            while (!found && waited < 10) begin
                step();
                if (k == 0 && waited == 0) begin
                    addr_from_pnl = 10'o0001; wdata_from_pnl = '1; we_from_pnl = 1'b0;
                    addr_from_io = 10'o0002; wdata_from_io = '0; addr_from_pu = 10'o0003;
                end
                samp();
                waited++;
                if (mem_req_to_mem) found = 1'b1;
            end
            checks++; if (!found || waited != 2) begin errors++; $display("FAIL sim_strobe_latency[%0d]: got found=%b cycles=%0d expected found=1 cycles=2", k, found, waited); end
            checks++; if (we_to_mem !== exp_we[k] || addr_to_mem !== exp_addr[k]) begin
                errors++; $display("FAIL sim_we_addr[%0d]: got we=%b addr=%0o expected we=%b addr=%0o", k, we_to_mem, addr_to_mem, exp_we[k], exp_addr[k]); end
            if (chk_wdata[k]) begin
                checks++; if (wdata_to_mem !== exp_wdata[k]) begin errors++; $display("FAIL sim_wdata[%0d]: got %0h expected %0h", k, wdata_to_mem, exp_wdata[k]); end
            end
            step(); step(); reply_from_mem = 1'b1;
            samp();
            checks++; if ({reply_to_pu, reply_to_io, reply_to_pnl} !== exp_rep[k]) begin
                errors++; $display("FAIL sim_reply_route[%0d]: got %b expected %b", k, {reply_to_pu, reply_to_io, reply_to_pnl}, exp_rep[k]); end
        end
        step(); samp();
        checks++; if (arb_state_to_pnl !== 2'd0) begin errors++; $display("FAIL sim_end_state: got %0d expected 0", arb_state_to_pnl); end
    endtask

    task automatic test_overrun();
        int b_s;
        b_s = n_strobe;
        step(); mem_read_from_pu = 1'b1; addr_from_pu = 10'o0100;    // t
        step(); step();                                               // t+1, t+2
        step(); mem_read_from_pu = 1'b1; addr_from_pu = 10'o0200;    // t+3 (WAIT)
        samp();
        checks++; if (arb_state_to_pnl !== 2'd2) begin errors++; $display("FAIL ovr_wait_state: got %0d expected 2", arb_state_to_pnl); end
        step(); samp();                                               // t+4
        checks++; if (overrun_to_pnl !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun_to_pnl); end
        step(); reply_from_mem = 1'b1; samp();                        // t+5
        checks++; if (reply_to_pu !== 1'b1) begin errors++; $display("FAIL ovr_reply: got %b expected 1", reply_to_pu); end
        repeat (4) step();
        samp();
        checks++; if ((n_strobe - b_s) != 1 || arb_state_to_pnl !== 2'd0) begin
            errors++; $display("FAIL ovr_single_strobe: got strobes=%0d state=%0d expected 1 0", n_strobe - b_s, arb_state_to_pnl); end
        checks++; if (overrun_to_pnl !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun_to_pnl); end
        step(); clear_arb_from_pnl = 1'b1;
        step(); samp();
        checks++; if (overrun_to_pnl !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun_to_pnl); end
        // Clear beats a same-cycle request, which is dropped silently
        b_s = n_strobe;
        step(); clear_arb_from_pnl = 1'b1; mem_write_from_io = 1'b1; addr_from_io = 10'o0321;
        step(); samp();
        checks++; if (overrun_to_pnl !== 1'b0) begin errors++; $display("FAIL clr_drop_no_overrun: got %b expected 0", overrun_to_pnl); end
        repeat (4) step();
        checks++; if ((n_strobe - b_s) != 0 || arb_state_to_pnl !== 2'd0) begin
            errors++; $display("FAIL clr_drop_no_strobe: got strobes=%0d state=%0d expected 0 0", n_strobe - b_s, arb_state_to_pnl); end
    endtask

    task automatic test_spurious_and_reset();
        int b_s, b_r;
        b_s = n_strobe; b_r = n_rpu + n_rio + n_rpnl;
        step(); reply_from_mem = 1'b1; samp();
        checks++; if ({reply_to_pu, reply_to_io, reply_to_pnl} !== 3'b000) begin errors++; $display("FAIL spur_reply: got %b expected 000", {reply_to_pu, reply_to_io, reply_to_pnl}); end
        step(); samp();
        checks++; if (arb_state_to_pnl !== 2'd0 || mem_req_to_mem !== 1'b0) begin errors++; $display("FAIL spur_state: got state=%0d req=%b expected 0 0", arb_state_to_pnl, mem_req_to_mem); end
        step(); mem_read_from_pu = 1'b1; addr_from_pu = 10'o0404;    // t
        step(); step();                                               // t+1, t+2
        step(); resetn = 1'b0; samp();                                // t+3 (WAIT, reset sampled at next edge)
        checks++; if (arb_state_to_pnl !== 2'd2) begin errors++; $display("FAIL rst_pre_state: got %0d expected 2", arb_state_to_pnl); end
        step(); resetn = 1'b1; samp();                                // t+4
        checks++; if ({arb_state_to_pnl, mem_req_to_mem, we_to_mem, overrun_to_pnl} !== 5'b0) begin
            errors++; $display("FAIL rst_wait_outputs: got %b expected 00000", {arb_state_to_pnl, mem_req_to_mem, we_to_mem, overrun_to_pnl}); end
        checks++; if (addr_to_mem !== '0 || wdata_to_mem !== '0) begin errors++; $display("FAIL rst_wait_bus: got addr=%0o wdata=%0h expected 0 0", addr_to_mem, wdata_to_mem); end
        step(); reply_from_mem = 1'b1; samp();                        // late reply
        checks++; if ({reply_to_pu, reply_to_io, reply_to_pnl} !== 3'b000) begin errors++; $display("FAIL rst_late_reply: got %b expected 000", {reply_to_pu, reply_to_io, reply_to_pnl}); end
        step(); step(); samp();
        checks++; if (arb_state_to_pnl !== 2'd0 || (n_strobe - b_s) != 1 || (n_rpu + n_rio + n_rpnl - b_r) != 0) begin
            errors++; $display("FAIL rst_after: got state=%0d strobes=%0d replies=%0d expected 0 1 0",
                               arb_state_to_pnl, n_strobe - b_s, n_rpu + n_rio + n_rpnl - b_r); end
    endtask

    task automatic test_timeout();
        step(); mem_read_from_pu = 1'b1; addr_from_pu = 10'o0007;    // t
        step(); mem_write_from_io = 1'b1; addr_from_io = 10'o0011; wdata_from_io = 37'h5;  // t+1
        step(); samp();                                               // t+2
        checks++; if (mem_req_to_mem !== 1'b1 || addr_to_mem !== 10'o0007) begin errors++; $display("FAIL to_strobe: got req=%b addr=%0o expected 1 7", mem_req_to_mem, addr_to_mem); end
        step(); samp();                                               // t+3: first WAIT cycle
        checks++; if (arb_state_to_pnl !== 2'd2) begin errors++; $display("FAIL to_wait_state: got %0d expected 2", arb_state_to_pnl); end
        repeat (7) step();                                            // t+10
        samp();
        checks++; if (reply_to_pu !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", reply_to_pu); end
`ifdef MEM_ARB_TIMEOUT_EN
        step(); samp();                                               // t+11 = WAIT entry + 8
        checks++; if ({reply_to_pu, reply_to_io, reply_to_pnl} !== 3'b100) begin errors++; $display("FAIL to_fire: got %b expected 100", {reply_to_pu, reply_to_io, reply_to_pnl}); end
        step(); samp();                                               // t+12
        checks++; if (timeout_to_pnl !== 1'b1 || arb_state_to_pnl !== 2'd0) begin errors++; $display("FAIL to_flag_idle: got flag=%b state=%0d expected 1 0", timeout_to_pnl, arb_state_to_pnl); end
        step(); samp();                                               // t+13
        checks++; if ({mem_req_to_mem, we_to_mem} !== 2'b11 || addr_to_mem !== 10'o0011 || wdata_to_mem !== 37'h5) begin
            errors++; $display("FAIL to_next_io: got req_we=%b addr=%0o wdata=%0h expected 11 11 5", {mem_req_to_mem, we_to_mem}, addr_to_mem, wdata_to_mem); end
        step(); step(); reply_from_mem = 1'b1; samp();
        checks++; if ({reply_to_pu, reply_to_io, reply_to_pnl} !== 3'b010) begin errors++; $display("FAIL to_io_reply: got %b expected 010", {reply_to_pu, reply_to_io, reply_to_pnl}); end
        step(); clear_arb_from_pnl = 1'b1;
        step(); samp();
        checks++; if (timeout_to_pnl !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", timeout_to_pnl); end
`else
        repeat (20) step();
        samp();
        checks++; if (arb_state_to_pnl !== 2'd2 || timeout_to_pnl !== 1'b0) begin errors++; $display("FAIL nto_stays_wait: got state=%0d flag=%b expected 2 0", arb_state_to_pnl, timeout_to_pnl); end
        checks++; if ({reply_to_pu, reply_to_io, reply_to_pnl} !== 3'b000) begin errors++; $display("FAIL nto_no_reply: got %b expected 000", {reply_to_pu, reply_to_io, reply_to_pnl}); end
        step(); clear_arb_from_pnl = 1'b1;
        step(); samp();
        checks++; if (arb_state_to_pnl !== 2'd0) begin errors++; $display("FAIL nto_clear_state: got %0d expected 0", arb_state_to_pnl); end
        repeat (3) step();
        samp();
        checks++; if (mem_req_to_mem !== 1'b0 || arb_state_to_pnl !== 2'd0) begin errors++; $display("FAIL nto_pending_cleared: got req=%b state=%0d expected 0 0", mem_req_to_mem, arb_state_to_pnl); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_pu();
        test_simultaneous();
        test_overrun();
        test_spurious_and_reset();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port between three requesters: the pulse unit (instruction/operand reads), the io unit (input-device writes) and the panel (manual read/write). Each requester issues a one-cycle request pulse. The arbiter latches it, serialises access with a fixed priority, drives the memory request pulse with the winner's address and data, and routes the memory reply pulse back to that requester only. It sits between pulse_unit, io_unit, pnl and mem.

## Interface
Parameters:
- ADDR_W, 10, memory address width
- DATA_W, 37, memory word width
- TIMEOUT_CYCLES, 255, reply watchdog limit (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  single clock; all state updates on posedge
- resetn  in  1  reset, synchronous, active-low
- mem_read_from_pu  in  1  pulse, read request from pulse unit
- addr_from_pu  in  ADDR_W  level, pulse-unit address (select register)
- mem_write_from_io  in  1  pulse, write request from io unit
- addr_from_io  in  ADDR_W  level, io write address
- wdata_from_io  in  DATA_W  level, io write data
- mem_req_from_pnl  in  1  pulse, panel request
- we_from_pnl  in  1  level, panel request is a write (1) or read (0)
- addr_from_pnl  in  ADDR_W  level, panel address
- wdata_from_pnl  in  DATA_W  level, panel write data
- clear_arb_from_pnl  in  1  pulse, abort and clear all pending requests
- mem_req_to_mem  out  1  pulse, memory access strobe
- we_to_mem  out  1  level, write enable qualifying mem_req_to_mem
- addr_to_mem  out  ADDR_W  level, access address
- wdata_to_mem  out  DATA_W  level, write data
- reply_from_mem  in  1  pulse, access complete
- reply_to_pu / reply_to_io / reply_to_pnl  out  1 each  pulse, routed reply
- overrun_to_pnl  out  1  level, sticky, a request was dropped
- timeout_to_pnl  out  1  level, sticky, watchdog fired
- arb_state_to_pnl  out  2  level, current FSM state

## Operation
- Each requester has a pending bit and a request register. A request pulse sets the pending bit. It also captures address, data and we (pu: we=0, io: we=1, pnl: we_from_pnl).
- A request pulse is dropped if that requester's pending bit is set or it owns the current access. A dropped request sets overrun_to_pnl.
- FSM encoding: IDLE=0, ISSUE=1, WAIT=2.
  - IDLE: if any pending bit is set, choose the winner by fixed priority pnl > pu > io. Record the owner, clear the winner's pending bit, load the output registers, and go to ISSUE.
  - ISSUE: mem_req_to_mem=1 for exactly this cycle, then go to WAIT.
  - WAIT: on reply_from_mem, assert reply_to_<owner> in the same cycle (combinational forward) and go to IDLE.
- addr_to_mem, wdata_to_mem and we_to_mem are held stable from ISSUE through WAIT.
- reply_from_mem outside WAIT is ignored and is not forwarded.
- clear_arb_from_pnl:
  - State goes to IDLE and all pending bits are cleared.
  - overrun_to_pnl and timeout_to_pnl are cleared.
  - No reply is forwarded.
  - It has priority over a same-cycle request pulse, which is dropped without setting overrun.
- Reset: state IDLE, pending bits 0, owner none. All outputs 0: mem_req_to_mem, we_to_mem, addr_to_mem, wdata_to_mem, all reply_to_* outputs, both sticky flags, arb_state_to_pnl.
- A reset during WAIT abandons the access; a late reply is ignored.

## Timing
- Request pulse at cycle t sets pending at t+1.
- With the FSM in IDLE at t+1, it is in ISSUE at t+2 with mem_req_to_mem=1.
- The reply at cycle r (r ≥ t+3) produces reply_to_owner at r. The FSM is in IDLE at r+1, and the next strobe comes no earlier than r+2.
- A request arriving in the same cycle as the reply is latched normally and serviced in the next IDLE.
- Simultaneous requests from all three are serviced in the order pnl, pu, io. The pu request waits at most one panel access.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT. If reply_from_mem is absent for TIMEOUT_CYCLES consecutive WAIT cycles, reply_to_<owner> pulses anyway, timeout_to_pnl sets, and the FSM goes to IDLE.
  - The counter clears on entry to WAIT.
- MEM_ARB_TIMEOUT_EN undefined: WAIT persists until a reply, clear or reset. timeout_to_pnl is constant 0 and no counter is synthesised.

## Test plan
- Single pu read, addr=0o1234, reply 3 cycles after strobe:
  - mem_req_to_mem at t+2 with we=0 and addr=0o1234.
  - reply_to_pu pulses once; reply_to_io and reply_to_pnl stay 0.
- pnl write, io write and pu read pulsed in the same cycle: strobes occur in order pnl (we=1), pu (we=0), io (we=1), each with its captured addr/wdata, and each reply is routed to the matching requester.
- Second pu pulse while pu owns the access: it is dropped, overrun_to_pnl=1, and only one strobe is issued. clear_arb_from_pnl then returns overrun_to_pnl to 0.
- Spurious reply_from_mem in IDLE: no reply_* output and no state change. resetn=0 during WAIT followed by a late reply: outputs stay 0 and state stays IDLE.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never replies:
  - reply_to_pu fires 8 cycles after entering WAIT, timeout_to_pnl=1, and the next pending request is serviced.
  - Without the macro the FSM remains in WAIT (state 2).
